// File: rtl/led_fade_driver_if.sv
// Pattern-in / PWM-out bundle between the run-light rotator, the fade driver and the LED pins.
interface led_fade_driver_if;
   logic [3:0] led_in;
   logic [3:0] led_out;
   logic       pwm_sync;

   modport master (output led_in, input led_out, input pwm_sync);
   modport slave  (input led_in, output led_out, output pwm_sync);
endinterface

// File: rtl/led_fade_driver.sv
// PWM LED driver with per-channel fade-out ("comet trail") behind the 4-LED run-light.
// Brightness is latched into shadow registers at each PWM period boundary so a period never glitches.
module led_fade_driver #(
   parameter int unsigned PWM_BITS   = 8,
   parameter int unsigned DECAY_DIV  = 32'd50_000,
   parameter int unsigned DECAY_STEP = 16,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   led_fade_driver_if.slave bus
);

   localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] PWM_LAST = MAX - PWM_BITS'(1);
   localparam logic [31:0]         DIV_LAST = 32'(DECAY_DIV - 1);
   localparam logic [3:0]          ALL_OFF  = {4{ACTIVE_LOW}};

   // Saturating subtract; a step at or above MAX empties the channel in one tick.
   function automatic logic [PWM_BITS-1:0] sat_decay(input logic [PWM_BITS-1:0] lvl);
      logic [31:0] lvl32;
      lvl32 = 32'(lvl);
      if (lvl32 > DECAY_STEP) sat_decay = PWM_BITS'(lvl32 - DECAY_STEP);
      else                    sat_decay = '0;
   endfunction

   logic [3:0]          led_in_q,    led_in_d;
   logic [PWM_BITS-1:0] pwm_cnt_q,   pwm_cnt_d;
   logic [31:0]         decay_cnt_q, decay_cnt_d;
   logic [PWM_BITS-1:0] level_q [4];
   logic [PWM_BITS-1:0] level_d [4];
   logic [PWM_BITS-1:0] shadow_q [4];
   logic [PWM_BITS-1:0] shadow_d [4];
   logic [3:0]          led_out_q,   led_out_d;
   logic                pwm_sync_q,  pwm_sync_d;
   logic [3:0]          on;
   logic                decay_tick;
   logic                period_end;

   always_comb begin
      led_in_d    = bus.led_in;
      on          = led_in_q ^ ALL_OFF;
      period_end  = (pwm_cnt_q == PWM_LAST);
      pwm_cnt_d   = period_end ? '0 : pwm_cnt_q + PWM_BITS'(1);
      decay_tick  = (decay_cnt_q == DIV_LAST);
      decay_cnt_d = decay_tick ? '0 : decay_cnt_q + 32'd1;
      pwm_sync_d  = (pwm_cnt_q == '0);
      for (int i = 0; i < 4; i++) begin
         // A lit channel takes priority over a coincident decay tick.
         level_d[i] = level_q[i];
         if (on[i])           level_d[i] = MAX;
         else if (decay_tick) level_d[i] = sat_decay(level_q[i]);
         shadow_d[i]  = period_end ? level_q[i] : shadow_q[i];
         led_out_d[i] = (pwm_cnt_q < shadow_q[i]) ^ ACTIVE_LOW;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_in_q    <= ALL_OFF;
         pwm_cnt_q   <= '0;
         decay_cnt_q <= '0;
         led_out_q   <= ALL_OFF;
         pwm_sync_q  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            level_q[i]  <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         led_in_q    <= led_in_d;
         pwm_cnt_q   <= pwm_cnt_d;
         decay_cnt_q <= decay_cnt_d;
         led_out_q   <= led_out_d;
         pwm_sync_q  <= pwm_sync_d;
         for (int i = 0; i < 4; i++) begin
            level_q[i]  <= level_d[i];
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   assign bus.led_out  = led_out_q;
   assign bus.pwm_sync = pwm_sync_q;

endmodule
